ram_sync_writer: RTL and testbench
==================================

Name: ram_sync_writer

Overview:
- Writable counterpart of the board's synchronous ROM lookup: a 16x8 synchronous RAM loaded from switches and read back on demand.
- Data switches SW[11:4] are written to the address on SW[3:0] when the write button is pressed. The read button displays the stored byte.
- Sits between the board I/O and the existing clock_divider/display_mux/bcd_to_7seg chain. disp_data drives display_mux.data directly.
- Every write is read back and compared one cycle later (write-verify).

Parameters:
- ADDR_W, 4, address width; depth = 2**ADDR_W.
- DATA_W, 8, word width.
- DEBOUNCE_CYCLES, 1_000_000, stable-level cycles required before a button press is accepted (10 ms at 100 MHz).

Ports:
- clk  in  1  100 MHz board clock.
- rst_n  in  1  asynchronous, active-low reset.
- wr_btn  in  1  raw write pushbutton, asynchronous, bouncy.
- rd_btn  in  1  raw read pushbutton, asynchronous, bouncy.
- address  in  ADDR_W  address switches.
- wr_data  in  DATA_W  data switches.
- disp_data  out  DATA_W  byte shown on the display.
- busy  out  1  high while the FSM is outside IDLE.
- wr_done  out  1  one-cycle pulse when a write completes verification.
- verify_err  out  1  sticky flag: set on a readback mismatch, cleared only by reset.

Behaviour:
- Reset (rst_n=0, async):
  - FSM to IDLE.
  - disp_data=0, busy=0, wr_done=0, verify_err=0.
  - Debouncer counters, synchronisers and edge registers cleared.
  - RAM contents cleared to 0 (register file, 16 words).
- Button conditioning (per button):
  - 2-flop synchroniser.
  - Counter restarts on any level change and saturates at DEBOUNCE_CYCLES-1, then the debounced level updates.
  - Rising edge of the debounced level gives a 1-cycle press pulse.
  - Release is debounced identically; holding a button produces exactly one pulse.
- Capture: address and wr_data are registered on the press-pulse cycle. Later switch changes do not affect the operation in flight.
- FSM states: IDLE, WRITE, VERIFY, READ.
  - IDLE: wr pulse -> WRITE; rd pulse -> READ. If both pulse in the same cycle, write wins and the read pulse is dropped.
  - WRITE (1 cycle): mem[addr_q] <= data_q; -> VERIFY.
  - VERIFY (1 cycle): compare mem[addr_q] with data_q; disp_data <= mem[addr_q].
    - On match: wr_done=1 for this cycle only.
    - On mismatch: verify_err <= 1 and no wr_done.
    - -> IDLE.
  - READ (1 cycle): disp_data <= mem[addr_q]; -> IDLE.
- Timing and output rules:
  - Press pulses arriving while busy=1 are ignored, not queued.
  - busy=1 exactly in WRITE, VERIFY and READ.
  - Latency from press pulse to disp_data updated: write = 3 clocks, read = 2 clocks.
  - disp_data holds its value in IDLE.
- Address wrap: none; all 16 addresses are valid and there is no out-of-range case.
- Reset mid-operation: returns to IDLE immediately. A write interrupted before WRITE completes leaves the RAM cleared (reset clears the RAM).
- Display caveat: bcd_to_7seg blanks nibbles A-F; disp_data is still the raw byte.

Decomposition:
- Package ram_writer_pkg:
  - ADDR_W and DATA_W defaults.
  - FSM state encoding: IDLE=2'd0, WRITE=2'd1, VERIFY=2'd2, READ=2'd3.
  - Default DEBOUNCE_CYCLES.
- One sub-module: btn_debounce (synchroniser + debounce counter + rising-edge pulse), instantiated twice.
- RAM array and FSM live in the top module.

Test Plan (DEBOUNCE_CYCLES=4 for simulation):
- Reset, then read addr 0x5 -> disp_data=0x00 two clocks after the pulse; busy high for 1 cycle.
- Write 0x46 to 0x5, then read 0x5 -> wr_done pulses once 2 clocks after the press pulse, disp_data=0x46; the read returns 0x46.
- Bounce wr_btn (toggle every 2 cycles for 20 cycles, then hold high 10 cycles) -> exactly one write and one wr_done.
- Press wr_btn and rd_btn on the same cycle with addr 0x3, data 0x83 -> write only; mem[3]=0x83; no READ state entered.
- Change address from 0x3 to 0x9 during WRITE -> data lands at 0x3; mem[9] unchanged.
- Assert rst_n low during VERIFY after writing 0x88 to 0xE -> outputs 0, FSM IDLE; a subsequent read of 0xE returns 0x00; verify_err=0.

Source files
------------

// File: rtl/ram_writer_pkg.sv
// Shared widths, debounce default and FSM encoding for the switch-loaded RAM writer.
package ram_writer_pkg;

    localparam int unsigned ADDR_W_DEF          = 4;
    localparam int unsigned DATA_W_DEF          = 8;
    localparam int unsigned DEBOUNCE_CYCLES_DEF = 1_000_000;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StWrite  = 2'd1,
        StVerify = 2'd2,
        StRead   = 2'd3
    } state_t;

endpackage

// File: rtl/btn_debounce.sv
// Pushbutton conditioner: 2-flop synchroniser, stable-level debounce counter, press pulse.
module btn_debounce
    import ram_writer_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic press
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_a_q, sync_b_q, level_q;
    logic             stable_q, stable_prev_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // level_q is the previous synchronised sample; any difference restarts the count.
    always_comb begin
        cnt_d = cnt_q;
        if (sync_b_q != level_q) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_a_q      <= 1'b0;
            sync_b_q      <= 1'b0;
            level_q       <= 1'b0;
            cnt_q         <= '0;
            stable_q      <= 1'b0;
            stable_prev_q <= 1'b0;
        end else begin
            sync_a_q      <= btn;
            sync_b_q      <= sync_a_q;
            level_q       <= sync_b_q;
            cnt_q         <= cnt_d;
            stable_prev_q <= stable_q;
            if (cnt_q == CNT_MAX && sync_b_q == level_q) begin
                stable_q <= level_q;
            end
        end
    end

    assign press = stable_q & ~stable_prev_q;

endmodule

// File: rtl/ram_sync_writer.sv
// 16x8 register-file RAM written from switches with one-cycle readback verify,
// and read back to the display on demand.
module ram_sync_writer
    import ram_writer_pkg::*;
#(
    parameter int unsigned ADDR_W          = ADDR_W_DEF,
    parameter int unsigned DATA_W          = DATA_W_DEF,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_btn,
    input  logic              rd_btn,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] disp_data,
    output logic              busy,
    output logic              wr_done,
    output logic              verify_err
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic              wr_press, rd_press;
    state_t            state_q, state_d;
    logic              capture;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] disp_q;
    logic              err_q;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_word;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_wr_debounce (
        .clk  (clk),
        .rst_n(rst_n),
        .btn  (wr_btn),
        .press(wr_press)
    );

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_rd_debounce (
        .clk  (clk),
        .rst_n(rst_n),
        .btn  (rd_btn),
        .press(rd_press)
    );

    assign rd_word = mem[addr_q];

    // Presses outside IDLE are dropped; a simultaneous write press beats the read.
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        wr_done = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (wr_press) begin
                    state_d = StWrite;
                    capture = 1'b1;
                end else if (rd_press) begin
                    state_d = StRead;
                    capture = 1'b1;
                end
            end
            StWrite:  state_d = StVerify;
            StVerify: begin
                state_d = StIdle;
                wr_done = (rd_word == data_q);
            end
            StRead:   state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            addr_q  <= '0;
            data_q  <= '0;
            disp_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                addr_q <= address;
                data_q <= wr_data;
            end
            if (state_q == StVerify || state_q == StRead) begin
                disp_q <= rd_word;
            end
            if (state_q == StVerify && rd_word != data_q) begin
                err_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (state_q == StWrite) begin
            mem[addr_q] <= data_q;
        end
    end

    assign busy       = (state_q != StIdle);
    assign disp_data  = disp_q;
    assign verify_err = err_q;

endmodule

// File: tb/tb_ram_sync_writer.sv
// Scoreboard bench: stimulus pushes expected per-operation results, a negedge monitor
// pops one entry each time an operation ends (busy falls) and compares.
module tb_ram_sync_writer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_btn, rd_btn;
    logic [3:0] address;
    logic [7:0] wr_data;
    logic [7:0] disp_data;
    logic       busy, wr_done, verify_err;

    int checks = 0;
    int errors = 0;
    int ops_seen = 0;
    int ops_pushed = 0;

    typedef struct {
        logic [7:0] data;
        int         busy_cycles;
        int         dones;
    } exp_t;

    exp_t exp_q[$];

    ram_sync_writer #(
        .ADDR_W         (4),
        .DATA_W         (8),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_btn    (wr_btn),
        .rd_btn    (rd_btn),
        .address   (address),
        .wr_data   (wr_data),
        .disp_data (disp_data),
        .busy      (busy),
        .wr_done   (wr_done),
        .verify_err(verify_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] d, input int bc, input int dn);
        exp_t e;
        e.data        = d;
        e.busy_cycles = bc;
        e.dones       = dn;
        exp_q.push_back(e);
        ops_pushed++;
    endtask

    task automatic press(input logic [3:0] a, input logic [7:0] d, input logic w, input logic r);
        address = a;
        wr_data = d;
        wr_btn  = w;
        rd_btn  = r;
        repeat (12) @(posedge clk);
        #1;
        wr_btn = 1'b0;
        rd_btn = 1'b0;
        repeat (12) @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [3:0] a, input logic [7:0] d);
        push(d, 2, 1);
        press(a, d, 1'b1, 1'b0);
    endtask

    task automatic do_read(input logic [3:0] a, input logic [7:0] exp);
        push(exp, 1, 0);
        press(a, 8'h00, 1'b0, 1'b1);
    endtask

    task automatic wait_busy();
        int n = 0;
        while (!busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!busy) check("busy_timeout", 32'(busy), 32'd1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_disp"}, 32'(disp_data), 32'h0);
        check({tag, "_busy"}, 32'(busy), 32'h0);
        check({tag, "_wr_done"}, 32'(wr_done), 32'h0);
        check({tag, "_verify_err"}, 32'(verify_err), 32'h0);
    endtask

    // Monitor
    int   cur_busy = 0;
    int   cur_done = 0;
    logic prev_busy = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            cur_busy  = 0;
            cur_done  = 0;
            prev_busy = 1'b0;
        end else begin
            if (busy) begin
                cur_busy++;
                if (wr_done) cur_done++;
            end else if (wr_done) begin
                check("wr_done_while_idle", 32'(wr_done), 32'h0);
            end
            if (prev_busy && !busy) begin
                ops_seen++;
                if (exp_q.size() == 0) begin
                    check("unexpected_op", 32'(ops_seen), 32'(ops_pushed));
                end else begin
                    e = exp_q.pop_front();
                    check("op_disp_data", 32'(disp_data), 32'(e.data));
                    check("op_busy_cycles", 32'(cur_busy), 32'(e.busy_cycles));
                    check("op_wr_done_count", 32'(cur_done), 32'(e.dones));
                    check("op_verify_err", 32'(verify_err), 32'h0);
                end
                cur_busy = 0;
                cur_done = 0;
            end
            prev_busy = busy;
        end
    end

    initial begin
        rst_n   = 1'b0;
        wr_btn  = 1'b0;
        rd_btn  = 1'b0;
        address = 4'h0;
        wr_data = 8'h00;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Fresh RAM reads zero
        do_read(4'h5, 8'h00);

        // Write then read back
        do_write(4'h5, 8'h46);
        do_read(4'h5, 8'h46);

        // Bouncy write: toggling every 2 cycles must not register, the long hold must once
        push(8'h3C, 2, 1);
        address = 4'h7;
        wr_data = 8'h3C;
        for (int i = 0; i < 10; i++) begin
            wr_btn = (i % 2 == 0);
            repeat (2) @(posedge clk);
            #1;
        end
        wr_btn = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        wr_btn = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        do_read(4'h7, 8'h3C);

        // Simultaneous presses: write only
        push(8'h83, 2, 1);
        press(4'h3, 8'h83, 1'b1, 1'b1);
        do_read(4'h3, 8'h83);

        // Address change during WRITE must not redirect the write
        do_write(4'h9, 8'h5A);
        push(8'h11, 2, 1);
        address = 4'h3;
        wr_data = 8'h11;
        wr_btn  = 1'b1;
        wait_busy();
        address = 4'h9;
        repeat (12) @(posedge clk);
        #1;
        wr_btn = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        do_read(4'h9, 8'h5A);
        do_read(4'h3, 8'h11);

        // Reset during VERIFY: no completion expected for this write
        address = 4'hE;
        wr_data = 8'h88;
        wr_btn  = 1'b1;
        wait_busy();
        @(posedge clk);
        #1;
        rst_n  = 1'b0;
        wr_btn = 1'b0;
        @(negedge clk);
        check_idle_outputs("midop_reset");
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        do_read(4'hE, 8'h00);
        do_read(4'h3, 8'h00);

        repeat (10) @(posedge clk);
        @(negedge clk);
        check("ops_completed", 32'(ops_seen), 32'(ops_pushed));
        check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
        check("final_verify_err", 32'(verify_err), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
